// File: rtl/alu_issue_ctrl.sv
// Issue controller for the one-hot-ALUop ALU: accepts a MIPS instruction with operands,
// decodes and registers the ALU inputs, captures the result and returns it with trap flags.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           inst,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [15:0]           alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_ovf_trap,
  output logic                  out_illegal
);

  localparam logic [15:0] OP_AND  = 16'h0001;
  localparam logic [15:0] OP_OR   = 16'h0002;
  localparam logic [15:0] OP_ADD  = 16'h0004;
  localparam logic [15:0] OP_SUB  = 16'h0008;
  localparam logic [15:0] OP_SLT  = 16'h0010;
  localparam logic [15:0] OP_XOR  = 16'h0020;
  localparam logic [15:0] OP_NOR  = 16'h0040;
  localparam logic [15:0] OP_SLTU = 16'h0080;
  localparam logic [15:0] OP_SLL  = 16'h0100;
  localparam logic [15:0] OP_SRL  = 16'h0200;
  localparam logic [15:0] OP_SRA  = 16'h0400;
  localparam logic [15:0] OP_LUI  = 16'h0800;
  localparam int          MSB     = DATA_WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [15:0]           aluop_q, aluop_d;
  logic                  trap_en_q, trap_en_d, illegal_q, illegal_d;
  logic                  zero_q, zero_d, ovf_q, ovf_d;

  logic [5:0]            opcode, funct;
  logic [DATA_WIDTH-1:0] imm_sext, imm_zext, shamt_zext, dec_a, dec_b;
  logic [15:0]           dec_op;
  logic                  dec_trap, dec_ill, ovf_raw;
  logic                  unused_inst_bits;

  assign opcode           = inst[31:26];
  assign funct            = inst[5:0];
  assign imm_sext         = {{(DATA_WIDTH-16){inst[15]}}, inst[15:0]};
  assign imm_zext         = {{(DATA_WIDTH-16){1'b0}}, inst[15:0]};
  assign shamt_zext       = {{(DATA_WIDTH-5){1'b0}}, inst[10:6]};
  assign unused_inst_bits = ^inst[25:16];

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec_a    = rs_val;
    dec_b    = rt_val;
    dec_op   = '0;
    dec_trap = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00: begin dec_op = OP_SLL; dec_a = shamt_zext; end
          6'h02: begin dec_op = OP_SRL; dec_a = shamt_zext; end
          6'h03: begin dec_op = OP_SRA; dec_a = shamt_zext; end
          6'h04: dec_op = OP_SLL;
          6'h06: dec_op = OP_SRL;
          6'h07: dec_op = OP_SRA;
          6'h20: begin dec_op = OP_ADD; dec_trap = 1'b1; end
          6'h21: dec_op = OP_ADD;
          6'h22: begin dec_op = OP_SUB; dec_trap = 1'b1; end
          6'h23: dec_op = OP_SUB;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h26: dec_op = OP_XOR;
          6'h27: dec_op = OP_NOR;
          6'h2A: dec_op = OP_SLT;
          6'h2B: dec_op = OP_SLTU;
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08: begin dec_op = OP_ADD;  dec_b = imm_sext; dec_trap = 1'b1; end
      6'h09: begin dec_op = OP_ADD;  dec_b = imm_sext; end
      6'h0A: begin dec_op = OP_SLT;  dec_b = imm_sext; end
      6'h0B: begin dec_op = OP_SLTU; dec_b = imm_sext; end
      6'h0C: begin dec_op = OP_AND;  dec_b = imm_zext; end
      6'h0D: begin dec_op = OP_OR;   dec_b = imm_zext; end
      6'h0E: begin dec_op = OP_XOR;  dec_b = imm_zext; end
      6'h0F: begin dec_op = OP_LUI;  dec_b = imm_zext; dec_a = '0; end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_a = '0;
      dec_b = '0;
    end
  end

  // Signed overflow is judged from operand and result sign bits, not the ALU's own flag.
  always_comb begin
    ovf_raw = 1'b0;
    if (aluop_q == OP_ADD)
      ovf_raw = (a_q[MSB] == b_q[MSB]) && (alu_Result[MSB] != a_q[MSB]);
    else if (aluop_q == OP_SUB)
      ovf_raw = (a_q[MSB] != b_q[MSB]) && (alu_Result[MSB] != a_q[MSB]);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    aluop_d   = aluop_q;
    trap_en_d = trap_en_q;
    illegal_d = illegal_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d       = dec_a;
          b_d       = dec_b;
          aluop_d   = dec_op;
          trap_en_d = dec_trap;
          illegal_d = dec_ill;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = illegal_q ? '0   : alu_Result;
        zero_d   = illegal_q ? 1'b1 : alu_Zero;
        ovf_d    = trap_en_q && ovf_raw;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      aluop_q   <= '0;
      trap_en_q <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      aluop_q   <= aluop_d;
      trap_en_q <= trap_en_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign alu_A        = a_q;
  assign alu_B        = b_q;
  assign alu_ALUop    = aluop_q;
  assign out_result   = result_q;
  assign out_zero     = zero_q;
  assign out_ovf_trap = ovf_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU model, vector table,
// result scoreboard, plus backpressure and mid-flight reset sequences.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic        in_ready, out_valid, out_zero, out_ovf_trap, out_illegal, alu_Zero;
  logic [31:0] inst, rs_val, rt_val, alu_A, alu_B, alu_Result, out_result, m_res;
  logic [15:0] alu_ALUop;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] inst, rs, rt;
    logic [15:0] op;
    logic [31:0] a, b, res;
    logic        zero, ovf, ill;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        zero, ovf, ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  alu_issue_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .rs_val(rs_val), .rt_val(rt_val),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_Zero(alu_Zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_ovf_trap(out_ovf_trap), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural one-hot ALU, combinational from the controller's drive.
  always_comb begin
    m_res = '0;
    case (alu_ALUop)
      16'h0001: m_res = alu_A & alu_B;
      16'h0002: m_res = alu_A | alu_B;
      16'h0004: m_res = alu_A + alu_B;
      16'h0008: m_res = alu_A - alu_B;
      16'h0010: m_res = {31'b0, $signed(alu_A) < $signed(alu_B)};
      16'h0020: m_res = alu_A ^ alu_B;
      16'h0040: m_res = ~(alu_A | alu_B);
      16'h0080: m_res = {31'b0, alu_A < alu_B};
      16'h0100: m_res = alu_B << alu_A[4:0];
      16'h0200: m_res = alu_B >> alu_A[4:0];
      16'h0400: m_res = $unsigned($signed(alu_B) >>> alu_A[4:0]);
      16'h0800: m_res = {alu_B[15:0], 16'h0000};
      default:  m_res = '0;
    endcase
  end
  assign alu_Result = m_res;
  assign alu_Zero   = (m_res == 32'd0);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] shamt, input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, shamt, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 5'd1, 5'd2, imm};
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] i, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [15:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic z,
                              input logic o, input logic il);
    vec_t v;
    v.name = nm; v.inst = i; v.rs = rs; v.rt = rt; v.op = op; v.a = a; v.b = b;
    v.res = res; v.zero = z; v.ovf = o; v.ill = il;
    return v;
  endfunction

  // Presents a request in IDLE; returns at the negedge inside EXEC after checking the ALU drive.
  task automatic issue(input vec_t v);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({v.name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    inst     = v.inst;
    rs_val   = v.rs;
    rt_val   = v.rt;
    @(posedge clk);
    e.res = v.res; e.zero = v.zero; e.ovf = v.ovf; e.ill = v.ill;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    inst     = $urandom;
    rs_val   = $urandom;
    rt_val   = $urandom;
    check({v.name, " alu_ALUop"}, {16'b0, alu_ALUop}, {16'b0, v.op});
    check({v.name, " alu_A"}, alu_A, v.a);
    check({v.name, " alu_B"}, alu_B, v.b);
    check({v.name, " out_valid in EXEC"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic compare_out(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: result appeared with empty scoreboard", nm);
    end else begin
      e = sb.pop_front();
      check({nm, " out_result"}, out_result, e.res);
      check({nm, " out_zero"}, {31'b0, out_zero}, {31'b0, e.zero});
      check({nm, " out_ovf_trap"}, {31'b0, out_ovf_trap}, {31'b0, e.ovf});
      check({nm, " out_illegal"}, {31'b0, out_illegal}, {31'b0, e.ill});
    end
  endtask

  // Called from the EXEC negedge: expects DONE after the next edge, then handshakes.
  task automatic complete(input string nm);
    @(negedge clk);
    check({nm, " out_valid"}, {31'b0, out_valid}, 32'd1);
    compare_out(nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, " back to idle"}, {30'b0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    logic [31:0] held;
    vec_t        addu_a, addu_b;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    inst = '0; rs_val = '0; rt_val = '0;

    addu_a = mk("addu_5_7", rtype(0, 6'h21), 32'd5, 32'd7, 16'h0004, 32'd5, 32'd7, 32'd12, 0, 0, 0);
    addu_b = mk("addu_1_1", rtype(0, 6'h21), 32'd1, 32'd1, 16'h0004, 32'd1, 32'd1, 32'd2, 0, 0, 0);
    vecs.push_back(addu_a);
    vecs.push_back(mk("sra_4", rtype(4, 6'h03), 32'h1234_5678, 32'h8000_0000, 16'h0400, 32'd4, 32'h8000_0000, 32'hF800_0000, 0, 0, 0));
    vecs.push_back(mk("srlv_36", rtype(0, 6'h06), 32'd36, 32'h0000_00F0, 16'h0200, 32'd36, 32'h0000_00F0, 32'h0000_000F, 0, 0, 0));
    vecs.push_back(mk("sll_31", rtype(31, 6'h00), 32'hFFFF_FFFF, 32'd1, 16'h0100, 32'd31, 32'd1, 32'h8000_0000, 0, 0, 0));
    vecs.push_back(mk("addi_ovf", itype(6'h08, 16'h0001), 32'h7FFF_FFFF, 32'd0, 16'h0004, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1, 0));
    vecs.push_back(mk("addiu_noovf", itype(6'h09, 16'h0001), 32'h7FFF_FFFF, 32'd0, 16'h0004, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 0, 0));
    vecs.push_back(mk("sub_ovf", rtype(0, 6'h22), 32'h8000_0000, 32'd1, 16'h0008, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 0));
    vecs.push_back(mk("add_wrap_noovf", rtype(0, 6'h20), 32'hFFFF_FFFF, 32'd1, 16'h0004, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 0));
    vecs.push_back(mk("lui", itype(6'h0F, 16'h1234), 32'hDEAD_BEEF, 32'd0, 16'h0800, 32'd0, 32'h0000_1234, 32'h1234_0000, 0, 0, 0));
    vecs.push_back(mk("ori_zext", itype(6'h0D, 16'h8000), 32'd0, 32'd0, 16'h0002, 32'd0, 32'h0000_8000, 32'h0000_8000, 0, 0, 0));
    vecs.push_back(mk("andi_zext", itype(6'h0C, 16'h8000), 32'hFFFF_FFFF, 32'd0, 16'h0001, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_8000, 0, 0, 0));
    vecs.push_back(mk("slti_sext", itype(6'h0A, 16'h0000), 32'hFFFF_FFFF, 32'd0, 16'h0010, 32'hFFFF_FFFF, 32'd0, 32'd1, 0, 0, 0));
    vecs.push_back(mk("sltiu_sext", itype(6'h0B, 16'hFFFF), 32'd1, 32'd0, 16'h0080, 32'd1, 32'hFFFF_FFFF, 32'd1, 0, 0, 0));
    vecs.push_back(mk("subu_zero", rtype(0, 6'h23), 32'd3, 32'd3, 16'h0008, 32'd3, 32'd3, 32'd0, 1, 0, 0));
    vecs.push_back(mk("nor_zero", rtype(0, 6'h27), 32'd0, 32'd0, 16'h0040, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0, 0));
    vecs.push_back(mk("illegal_op3f", itype(6'h3F, 16'h1234), 32'd5, 32'd6, 16'h0000, 32'd0, 32'd0, 32'd0, 1, 0, 1));
    vecs.push_back(mk("illegal_fn01", rtype(0, 6'h01), 32'd5, 32'd6, 16'h0000, 32'd0, 32'd0, 32'd0, 1, 0, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset alu_ALUop", {16'b0, alu_ALUop}, 32'd0);
    check("reset alu_A", alu_A, 32'd0);
    check("reset alu_B", alu_B, 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset flags", {29'b0, out_zero, out_ovf_trap, out_illegal}, 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i]);
      complete(vecs[i].name);
    end

    // Backpressure: result held for 5 cycles while a competing request is ignored.
    issue(addu_a);
    @(negedge clk);
    check("bp out_valid", {31'b0, out_valid}, 32'd1);
    held     = out_result;
    in_valid = 1'b1;
    inst     = addu_b.inst;
    rs_val   = addu_b.rs;
    rt_val   = addu_b.rt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp hold out_valid", {31'b0, out_valid}, 32'd1);
      check("bp hold out_result", out_result, held);
      check("bp hold in_ready", {31'b0, in_ready}, 32'd0);
    end
    compare_out("bp");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp idle after handshake", {30'b0, in_ready, out_valid}, 32'b10);
    @(posedge clk);
    sb.push_back('{res: 32'd2, zero: 1'b0, ovf: 1'b0, ill: 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    check("bp next accepted", {16'b0, alu_ALUop}, 32'h0000_0004);
    check("bp next alu_A", alu_A, 32'd1);
    complete("bp_next");

    // Reset during EXEC discards the in-flight operation.
    issue(addu_a);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    check("abort in_ready", {31'b0, in_ready}, 32'd1);
    check("abort alu_ALUop", {16'b0, alu_ALUop}, 32'd0);
    check("abort out_result", out_result, 32'd0);
    issue(addu_b);
    complete("after_abort");

    check("scoreboard drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
